// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: value/control inputs and pin-side outputs of the seven-segment scanner
interface seven_seg_scanner_if;
  logic [31:0] SEVENSEGHEX;
  logic        LZ_BLANK;
  logic [7:0]  DP_MASK;
  logic [7:0]  ANODE;
  logic [6:0]  CATHODE;
  logic        DP;
  logic        FRAME;
  modport master (output SEVENSEGHEX, LZ_BLANK, DP_MASK, input ANODE, CATHODE, DP, FRAME);
  modport slave (input SEVENSEGHEX, LZ_BLANK, DP_MASK, output ANODE, CATHODE, DP, FRAME);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 8-digit common-anode display driver with per-frame latch
module seven_seg_scanner #(
  parameter int DIV = 100000
) (
  input logic CLK,
  input logic RESET,
  seven_seg_scanner_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   hex_q, hex_d;
  logic          lz_q, lz_d;
  logic [7:0]    dpm_q, dpm_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;
  logic          tick, latch, blank;
  logic [3:0]    nib;
  // Prescaler, digit index, frame latch and next-slot output pattern; outputs only change on tick
  always_comb begin
    tick = cnt_q == CW'(DIV - 1);
    latch = tick && idx_q == 3'd7;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q + {2'b00, tick};
    hex_d = latch ? bus.SEVENSEGHEX : hex_q;
    lz_d = latch ? bus.LZ_BLANK : lz_q;
    dpm_d = latch ? bus.DP_MASK : dpm_q;
    nib = hex_d[{idx_d, 2'b00} +: 4];
    blank = lz_d && idx_d != 3'd0 && (hex_d >> {idx_d, 2'b00}) == 32'd0;
    anode_d = tick ? (blank ? 8'hFF : ~(8'd1 << idx_d)) : anode_q;
    cathode_d = tick ? (blank ? 7'h7F : ~SEG[nib]) : cathode_q;
    dp_d = tick ? (blank | ~dpm_d[idx_d]) : dp_q;
    frame_d = latch;
  end
  // State and registered pins; reset darkens the display and parks idx at 7 so the first tick starts a frame
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
      idx_q <= 3'd7;
      hex_q <= '0;
      lz_q <= 1'b0;
      dpm_q <= '0;
      anode_q <= 8'hFF;
      cathode_q <= 7'h7F;
      dp_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hex_q <= hex_d;
      lz_q <= lz_d;
      dpm_q <= dpm_d;
      anode_q <= anode_d;
      cathode_q <= cathode_d;
      dp_q <= dp_d;
      frame_q <= frame_d;
    end
  end
  assign bus.ANODE = anode_q;
  assign bus.CATHODE = cathode_q;
  assign bus.DP = dp_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table-driven and sequence checks of the scanner with DIV=4
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int failed = 0;
  logic armed = 1'b0;
  seven_seg_scanner_if bus();
  seven_seg_scanner #(.DIV(4)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] hex;
    logic        lz;
    logic [7:0]  dpm;
    int          slot;
    logic [7:0]  an;
    logic [6:0]  cat;
    logic        dp;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic wait_frame();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.FRAME;
    end
    chk("frame_seen", {31'd0, seen}, 32'd1);
  endtask
  task automatic chk_dark(input string name);
    chk(name, {15'd0, bus.ANODE, bus.CATHODE, bus.DP, bus.FRAME}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
  endtask
  always @(negedge clk) begin
    if (armed) begin
      compared++;
      if ($countones(~bus.ANODE) > 1) begin
        failed++;
        $display("FAIL anode_onehot: got %h expected at most one low bit at %0t", bus.ANODE, $time);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[$];
    logic [6:0] tear [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    int per;
    tbl.push_back('{32'h01234567, 1'b0, 8'h00, 0, 8'hFE, 7'h78, 1'b1});
    tbl.push_back('{32'h01234567, 1'b0, 8'h00, 1, 8'hFD, 7'h02, 1'b1});
    tbl.push_back('{32'h01234567, 1'b0, 8'h00, 3, 8'hF7, 7'h19, 1'b1});
    tbl.push_back('{32'h01234567, 1'b0, 8'h00, 7, 8'h7F, 7'h40, 1'b1});
    tbl.push_back('{32'hFFFFFFFF, 1'b0, 8'h00, 2, 8'hFB, 7'h0E, 1'b1});
    tbl.push_back('{32'h000000A0, 1'b1, 8'h00, 0, 8'hFE, 7'h40, 1'b1});
    tbl.push_back('{32'h000000A0, 1'b1, 8'h00, 1, 8'hFD, 7'h08, 1'b1});
    tbl.push_back('{32'h000000A0, 1'b1, 8'h00, 2, 8'hFF, 7'h7F, 1'b1});
    tbl.push_back('{32'h000000A0, 1'b1, 8'h00, 7, 8'hFF, 7'h7F, 1'b1});
    tbl.push_back('{32'h00000000, 1'b1, 8'h00, 0, 8'hFE, 7'h40, 1'b1});
    tbl.push_back('{32'h00000000, 1'b1, 8'h00, 5, 8'hFF, 7'h7F, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 0, 8'hFE, 7'h0E, 1'b0});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 1, 8'hFD, 7'h06, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 2, 8'hFB, 7'h21, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 3, 8'hF7, 7'h46, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 4, 8'hEF, 7'h03, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 5, 8'hDF, 7'h08, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 6, 8'hBF, 7'h10, 1'b1});
    tbl.push_back('{32'h89ABCDEF, 1'b0, 8'h81, 7, 8'h7F, 7'h00, 1'b0});
    tbl.push_back('{32'h0000000F, 1'b0, 8'h00, 6, 8'hBF, 7'h40, 1'b1});
    tbl.push_back('{32'h00100000, 1'b1, 8'h00, 5, 8'hDF, 7'h79, 1'b1});
    tbl.push_back('{32'h00100000, 1'b1, 8'h00, 6, 8'hFF, 7'h7F, 1'b1});
    tbl.push_back('{32'h00000005, 1'b1, 8'hFF, 0, 8'hFE, 7'h12, 1'b0});
    tbl.push_back('{32'h00000005, 1'b1, 8'hFF, 3, 8'hFF, 7'h7F, 1'b1});
    bus.SEVENSEGHEX = 32'h01234567;
    bus.LZ_BLANK = 1'b0;
    bus.DP_MASK = 8'h00;
    repeat (2) begin
      @(negedge clk);
      armed = 1'b1;
      chk_dark("rst_dark");
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_dark("post_rst_dark");
    end
    @(negedge clk);
    chk("first_anode", {24'd0, bus.ANODE}, 32'hFE);
    chk("first_frame", {31'd0, bus.FRAME}, 32'd1);
    chk("first_cathode", {25'd0, bus.CATHODE}, 32'h78);
    @(negedge clk);
    chk("frame_one_cycle", {31'd0, bus.FRAME}, 32'd0);
    chk("slot0_hold", {24'd0, bus.ANODE}, 32'hFE);
    wait_frame();
    per = 0;
    for (int c = 1; c <= 40 && per == 0; c++) begin
      @(negedge clk);
      if (c == 3) chk("slot_last_cycle", {24'd0, bus.ANODE}, 32'hFE);
      if (c == 4) chk("slot_next", {24'd0, bus.ANODE}, 32'hFD);
      if (bus.FRAME) per = c;
    end
    chk("frame_period", per, 32);
    repeat (12) @(negedge clk);
    bus.SEVENSEGHEX = 32'hFFFFFFFF;
    for (int s = 0; s < 5; s++) begin
      chk("tear_cathode", {25'd0, bus.CATHODE}, {25'd0, tear[s]});
      repeat (4) @(negedge clk);
    end
    chk("tear_new_frame", {31'd0, bus.FRAME}, 32'd1);
    chk("tear_new_cathode", {25'd0, bus.CATHODE}, 32'h0E);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.SEVENSEGHEX = tbl[i].hex;
      bus.LZ_BLANK = tbl[i].lz;
      bus.DP_MASK = tbl[i].dpm;
      wait_frame();
      repeat (4 * tbl[i].slot) @(negedge clk);
      chk($sformatf("vec%0d_anode", i), {24'd0, bus.ANODE}, {24'd0, tbl[i].an});
      chk($sformatf("vec%0d_cathode", i), {25'd0, bus.CATHODE}, {25'd0, tbl[i].cat});
      chk($sformatf("vec%0d_dp", i), {31'd0, bus.DP}, {31'd0, tbl[i].dp});
    end
    bus.SEVENSEGHEX = 32'h01234567;
    bus.LZ_BLANK = 1'b0;
    bus.DP_MASK = 8'h00;
    wait_frame();
    repeat (21) @(negedge clk);
    chk("pre_rst_slot5", {24'd0, bus.ANODE}, 32'hDF);
    rst = 1'b1;
    @(negedge clk);
    chk_dark("mid_rst_dark");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_dark("mid_post_dark");
    end
    @(negedge clk);
    chk("mid_rst_anode", {24'd0, bus.ANODE}, 32'hFE);
    chk("mid_rst_frame", {31'd0, bus.FRAME}, 32'd1);
    chk("mid_rst_cathode", {25'd0, bus.CATHODE}, 32'h78);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit `SEVENSEGHEX` value produced by the processor wrapper and drives the physical anode and cathode pins. It sits between `Wrapper` and the top-level pins, as the display-side consumer of that interface. The value is latched once per scan frame so that no digit tears, and the block optionally blanks leading zeros and drives decimal points.

## Interface
- `DIV`, default 100000: clock cycles each digit is lit (1 ms at 100 MHz). Must be ≥ 2; sims use 4.
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `SEVENSEGHEX` in 32: value to display. Nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- `LZ_BLANK` in 1: leading-zero blanking enable.
- `DP_MASK` in 8: bit i=1 lights the decimal point of digit i.
- `ANODE` out 8: active-low digit enables. At most one bit is low at any time.
- `CATHODE` out 7: active-low segments; bit0=a … bit6=g.
- `DP` out 1: active-low decimal point.
- `FRAME` out 1: one-cycle pulse marking the start of a new frame.

## Operation
- **Prescaler:** `cnt` counts 0..DIV-1 and wraps. `tick` = (`cnt`==DIV-1).
- **Digit index:** `idx` advances on `tick`, 0→1→…→7→0.
- **Frame latch:** on `tick` with `idx`==7, the block latches `SEVENSEGHEX`, `LZ_BLANK` and `DP_MASK` into shadow registers. Display content comes only from the shadow registers, so input changes mid-frame are ignored until the next frame.
- **Registered outputs:** all outputs are registered. They update on the same edge that `idx` changes, computed from next-`idx` and next-shadow values.
- **Hex decode** (active-high pattern, gfedcba; `CATHODE` is its 7-bit inverse):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- **Leading-zero blanking:** with shadow LZ=1, digit i (i≥1) is blanked when nibbles i..7 are all zero. Digit 0 is never blanked. A blanked slot drives `ANODE`=FF, `CATHODE`=7F and `DP`=1. The slot keeps its full DIV-cycle duration, so refresh rate is unchanged.
- **Decimal point:** `DP`=~`DP_MASK`[idx] for non-blanked digits.
- **FRAME:** high exactly in the cycle the first digit-0 slot of a new frame begins, i.e. the edge after the latching tick.
- **Reset state:**
  - `cnt`=0.
  - Internal `idx`=7, so the first tick starts a frame.
  - Shadows cleared.
  - Outputs `ANODE`=FF, `CATHODE`=7F, `DP`=1, `FRAME`=0 (display dark).

## Timing
- The first lit digit appears on the DIV-th rising edge after the last edge sampling `RESET`=1. It is digit 0, with `FRAME`=1 in that cycle.
- Each digit slot lasts exactly DIV cycles. The frame period is 8·DIV cycles.
- Input-to-display latency ranges from 1 to 8·DIV cycles, depending on the frame phase.
- **Simultaneous events:** an input change in the same cycle as the latching tick is captured in that frame.
- **Reset mid-operation:** `RESET` high at any point makes the outputs dark on the next edge. Counters and shadows return to reset values, and the timing restarts as from power-up.
- **Anode invariant:** `ANODE` never has two low bits simultaneously, including across slot transitions, which switch in a single edge.

## Test plan
All scenarios use DIV=4.
- **Reset:** hold `RESET` for 2 cycles.
  - During reset and for 3 cycles after: `ANODE`=FF, `CATHODE`=7F, `DP`=1, `FRAME`=0.
  - 4th edge after release: `ANODE`=FE and `FRAME`=1 for exactly one cycle.
- **Plain scan:** `SEVENSEGHEX`=32'h01234567, LZ=0, `DP_MASK`=0.
  - Slot 0: `ANODE`=FE, `CATHODE`=78.
  - Slot 7: `ANODE`=7F, `CATHODE`=40.
  - Each slot lasts 4 cycles; `FRAME` pulses every 32 cycles.
- **Tearing:** switch to FFFFFFFF during slot 3.
  - Slots 3–7 still show digits 4..0 of the old value.
  - Next frame shows `CATHODE`=0E on all slots.
- **Leading zeros:** LZ=1.
  - Value 000000A0: slot 0 `CATHODE`=40, slot 1 `CATHODE`=08, slots 2–7 `ANODE`=FF.
  - Value 0: only slot 0 is lit, with `CATHODE`=40.
- **Decimal points:** `DP_MASK`=81 with any value, LZ=0. `DP`=0 only in slots 0 and 7.
- **Mid-frame reset:** assert `RESET` for 1 cycle during slot 5.
  - Next edge: dark outputs.
  - Digit 0 reappears 4 edges after release, with a `FRAME` pulse.
